pixel_streamer: RTL and testbench

Frame source for the edge-detection front end. Takes 32-bit packed pixel words from the host/DMA over a ready/valid interface and unpacks them into one 8-bit pixel per cycle with a valid strobe. The output feeds the line-buffer window loader. Row-credit flow control stops the streamer from getting more than NUM_LINE_BUFFERS rows ahead of the consumer.

---
 rtl/definitions_pkg.sv | 19 +
 rtl/row_credit_counter.sv | 35 +++
 rtl/pixel_streamer.sv | 176 +++++++++++++++++
 tb/tb_pixel_streamer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/definitions_pkg.sv
// Shared definitions for the edge-detection front end: streamer states,
// packing geometry and image size defaults.
package definitions_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_CREDIT,
    PAD,
    STREAM,
    DONE
  } streamer_state_t;

  localparam int PIXELS_PER_WORD          = 4;
  localparam int IMAGE_WIDTH_DEFAULT      = 512;
  localparam int IMAGE_HEIGHT_DEFAULT     = 512;
  localparam int NUM_LINE_BUFFERS_DEFAULT = 4;
  localparam logic [7:0] PAD_PIXEL        = 8'h00;

endpackage

// File: rtl/row_credit_counter.sv
// Saturating row-credit counter: starts full, increments on a released line
// buffer, decrements when a row begins, and flags when a credit is available.
module row_credit_counter #(
  parameter int MAX_CREDITS = 4
) (
  input  logic clk,
  input  logic rstN,
  input  logic inc,
  input  logic dec,
  output logic available
);

  localparam int CW = $clog2(MAX_CREDITS + 1);
  localparam logic [CW-1:0] FULL = CW'(MAX_CREDITS);

  logic [CW-1:0] count_reg, count_next;

  // A release and a row start in the same cycle cancel out.
  always_comb begin
    count_next = count_reg;
    if (inc && !dec) begin
      if (count_reg != FULL) count_next = count_reg + 1'b1;
    end else if (dec && !inc) begin
      count_next = count_reg - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstN) count_reg <= FULL;
    else       count_reg <= count_next;
  end

  assign available = (count_reg != '0);

endmodule

// File: rtl/pixel_streamer.sv
// Unpacks 32-bit pixel words into one 8-bit pixel per cycle with row-credit
// flow control. PIXEL_STREAMER_BORDER_PAD_EN adds a zero row above and below.
module pixel_streamer
  import definitions_pkg::*;
#(
  parameter int IMAGE_WIDTH      = IMAGE_WIDTH_DEFAULT,
  parameter int IMAGE_HEIGHT     = IMAGE_HEIGHT_DEFAULT,
  parameter int NUM_LINE_BUFFERS = NUM_LINE_BUFFERS_DEFAULT
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic        start,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic        row_done,
  output logic [7:0]  pixel_out,
  output logic        pixel_out_valid,
  output logic        pixel_eol,
  output logic        busy,
  output logic        frame_done
);

`ifdef PIXEL_STREAMER_BORDER_PAD_EN
  localparam int TOTAL_ROWS = IMAGE_HEIGHT + 2;
`else
  localparam int TOTAL_ROWS = IMAGE_HEIGHT;
`endif
  localparam int COL_W  = $clog2(IMAGE_WIDTH);
  localparam int ROW_W  = $clog2(TOTAL_ROWS + 1);
  localparam int BYTE_W = $clog2(PIXELS_PER_WORD);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(IMAGE_WIDTH - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(TOTAL_ROWS - 1);
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(PIXELS_PER_WORD - 1);

  streamer_state_t state_reg, state_next;
  logic [31:0]       word_reg, word_next;
  logic              word_valid_reg, word_valid_next;
  logic [BYTE_W-1:0] byte_idx_reg, byte_idx_next;
  logic [COL_W-1:0]  col_cnt_reg, col_cnt_next;
  logic [ROW_W-1:0]  row_cnt_reg, row_cnt_next;
  logic [7:0]        pixel_reg, pixel_next;
  logic              pixel_valid_reg, pixel_valid_next;
  logic              pixel_eol_reg, pixel_eol_next;
  logic              frame_done_reg, frame_done_next;
  logic              credit_take, credit_available;
  logic              end_of_row, last_row;

  row_credit_counter #(
    .MAX_CREDITS(NUM_LINE_BUFFERS)
  ) u_row_credit (
    .clk      (clk),
    .rstN     (rstN),
    .inc      (row_done),
    .dec      (credit_take),
    .available(credit_available)
  );

`ifdef PIXEL_STREAMER_BORDER_PAD_EN
  logic pad_row;
  assign pad_row = (row_cnt_reg == '0) || (row_cnt_reg == LAST_ROW);
`endif

  assign end_of_row = (col_cnt_reg == LAST_COL);
  assign last_row   = (row_cnt_reg == LAST_ROW);

  always_comb begin
    state_next       = state_reg;
    word_next        = word_reg;
    word_valid_next  = word_valid_reg;
    byte_idx_next    = byte_idx_reg;
    col_cnt_next     = col_cnt_reg;
    row_cnt_next     = row_cnt_reg;
    pixel_next       = PAD_PIXEL;
    pixel_valid_next = 1'b0;
    pixel_eol_next   = 1'b0;
    credit_take      = 1'b0;
    s_ready          = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          col_cnt_next = '0;
          row_cnt_next = '0;
          state_next   = WAIT_CREDIT;
        end
      end

      WAIT_CREDIT: begin
        if (credit_available) begin
          credit_take = 1'b1;
`ifdef PIXEL_STREAMER_BORDER_PAD_EN
          state_next  = pad_row ? PAD : STREAM;
`else
          state_next  = STREAM;
`endif
        end
      end

`ifdef PIXEL_STREAMER_BORDER_PAD_EN
      PAD: begin
        pixel_valid_next = 1'b1;
        col_cnt_next     = col_cnt_reg + 1'b1;
        if (end_of_row) begin
          pixel_eol_next = 1'b1;
          col_cnt_next   = '0;
          row_cnt_next   = row_cnt_reg + 1'b1;
          state_next     = last_row ? DONE : WAIT_CREDIT;
        end
      end
`endif

      STREAM: begin
        // The next word may only overlap the last byte if it belongs to this row.
        s_ready = !word_valid_reg || (byte_idx_reg == LAST_BYTE && !end_of_row);
        if (word_valid_reg) begin
          pixel_next       = word_reg[{byte_idx_reg, 3'b000} +: 8];
          pixel_valid_next = 1'b1;
          byte_idx_next    = byte_idx_reg + 1'b1;
          col_cnt_next     = col_cnt_reg + 1'b1;
          if (byte_idx_reg == LAST_BYTE) word_valid_next = 1'b0;
          if (end_of_row) begin
            pixel_eol_next  = 1'b1;
            col_cnt_next    = '0;
            row_cnt_next    = row_cnt_reg + 1'b1;
            word_valid_next = 1'b0;
            state_next      = last_row ? DONE : WAIT_CREDIT;
          end
        end
        if (s_valid && s_ready) begin
          word_next       = s_data;
          word_valid_next = 1'b1;
          byte_idx_next   = '0;
        end
      end

      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    frame_done_next = (state_reg == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_reg       <= IDLE;
      word_reg        <= '0;
      word_valid_reg  <= 1'b0;
      byte_idx_reg    <= '0;
      col_cnt_reg     <= '0;
      row_cnt_reg     <= '0;
      pixel_reg       <= 8'h00;
      pixel_valid_reg <= 1'b0;
      pixel_eol_reg   <= 1'b0;
      frame_done_reg  <= 1'b0;
    end else begin
      state_reg       <= state_next;
      word_reg        <= word_next;
      word_valid_reg  <= word_valid_next;
      byte_idx_reg    <= byte_idx_next;
      col_cnt_reg     <= col_cnt_next;
      row_cnt_reg     <= row_cnt_next;
      pixel_reg       <= pixel_next;
      pixel_valid_reg <= pixel_valid_next;
      pixel_eol_reg   <= pixel_eol_next;
      frame_done_reg  <= frame_done_next;
    end
  end

  assign pixel_out       = pixel_reg;
  assign pixel_out_valid = pixel_valid_reg;
  assign pixel_eol       = pixel_eol_reg;
  assign busy            = (state_reg != IDLE);
  assign frame_done      = frame_done_reg;

endmodule

// File: tb/tb_pixel_streamer.sv
// Randomized bench for pixel_streamer (W=8, H=6) against a frame-level model:
// expected pixels come from accepted words in order, plus zero rows when padded.
`timescale 1ns/1ps
module tb_pixel_streamer;
  import definitions_pkg::*;

  localparam int W   = 8;
  localparam int H   = 6;
  localparam int NLB = 4;
`ifdef PIXEL_STREAMER_BORDER_PAD_EN
  localparam int TOTAL_ROWS = H + 2;
  localparam bit PAD_EN     = 1'b1;
`else
  localparam int TOTAL_ROWS = H;
  localparam bit PAD_EN     = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        start = 1'b0;
  logic [31:0] s_data = 32'h03020100;
  logic        s_valid = 1'b0;
  logic        row_done = 1'b0;
  logic        s_ready, pixel_out_valid, pixel_eol, busy, frame_done;
  logic [7:0]  pixel_out;

  int checks = 0;
  int failures = 0;

  int  cyc = 0;
  int  vmode = 0;
  bit  auto_rd = 1'b0;
  bit  free_run = 1'b0;
  bit  hs_pending = 1'b0;
  int  nwords = 0;
  int  rows_total = 0;
  int  frames_done = 0;

  logic [7:0] byte_q[$];
  int exp_row = 0, exp_col = 0;
  int done_due = -1, last_valid_cyc = 0, last_eol_cyc = 0;

  pixel_streamer #(
    .IMAGE_WIDTH(W),
    .IMAGE_HEIGHT(H),
    .NUM_LINE_BUFFERS(NLB)
  ) dut (
    .clk            (clk),
    .rstN           (rstN),
    .start          (start),
    .s_data         (s_data),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .row_done       (row_done),
    .pixel_out      (pixel_out),
    .pixel_out_valid(pixel_out_valid),
    .pixel_eol      (pixel_eol),
    .busy           (busy),
    .frame_done     (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_pad_row(input int r);
    return PAD_EN && (r == 0 || r == TOTAL_ROWS - 1);
  endfunction

  // Source: holds data until accepted; valid pattern depends on vmode.
  initial begin
    int phase = 0;
    forever begin
      @(posedge clk); #1;
      if (hs_pending) begin
        $display("word %0d accepted data=0x%08h", nwords, s_data);
        nwords++;
        s_data = (nwords == 1) ? 32'h07060504 : $urandom;
      end
      phase++;
      case (vmode)
        0:       s_valid = 1'b1;
        1:       s_valid = ((phase / 4) % 2) == 0;
        default: s_valid = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor and reference model, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rstN) begin
        byte_q.delete();
        exp_row = 0; exp_col = 0; done_due = -1; hs_pending = 1'b0;
      end else begin
        hs_pending = s_valid && s_ready;
        if (hs_pending)
          for (int k = 0; k < 4; k++) byte_q.push_back(s_data[8*k +: 8]);
        if (pixel_out_valid) begin
          bit pad;
          logic [7:0] exp_pix;
          pad = is_pad_row(exp_row);
          check_value("pixel_has_source", 32'(pad || byte_q.size() != 0), 32'd1);
          if (pad || byte_q.size() != 0) begin
            exp_pix = pad ? PAD_PIXEL : byte_q.pop_front();
            check_value("pixel", 32'(pixel_out), 32'(exp_pix));
          end
          check_value("eol", 32'(pixel_eol), 32'(exp_col == W - 1));
          if (pad) check_value("s_ready_in_pad", 32'(s_ready), 32'd0);
          if (free_run && exp_col != 0) check_value("row_continuous", 32'(cyc - last_valid_cyc), 32'd1);
          if (free_run && exp_col == 0 && exp_row >= 1 && exp_row <= 3 && !pad)
            check_value("row_boundary_gap", 32'(cyc - last_eol_cyc), 32'd3);
          last_valid_cyc = cyc;
          if (exp_col == W - 1) begin
            exp_col = 0;
            last_eol_cyc = cyc;
            exp_row++;
            rows_total++;
            if (exp_row == TOTAL_ROWS) begin
              exp_row = 0;
              done_due = cyc + 1;
              check_value("no_leftover_words", 32'(byte_q.size()), 32'd0);
            end
          end else begin
            exp_col++;
          end
        end else begin
          check_value("eol_without_valid", 32'(pixel_eol), 32'd0);
        end
        if (frame_done || cyc == done_due) begin
          check_value("frame_done_timing", 32'(frame_done), 32'(cyc == done_due));
          if (frame_done) frames_done++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
    start = 1'b0;
    row_done = auto_rd && (cyc % 8 == 0);
  endtask

  task automatic wait_rows(input int n, input int budget);
    int k = 0;
    while (rows_total < n && k < budget) begin tick(); k++; end
    check_value("rows_reached", 32'(rows_total >= n), 32'd1);
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k = 0;
    while (frames_done < n && k < budget) begin tick(); k++; end
    check_value("frames_reached", 32'(frames_done >= n), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_value({tag, "_pixel_out"}, 32'(pixel_out), 32'd0);
    check_value({tag, "_valid"}, 32'(pixel_out_valid), 32'd0);
    check_value({tag, "_eol"}, 32'(pixel_eol), 32'd0);
    check_value({tag, "_busy"}, 32'(busy), 32'd0);
    check_value({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    check_value({tag, "_s_ready"}, 32'(s_ready), 32'd0);
    check_value({tag, "_credits"}, 32'(dut.u_row_credit.count_reg), 32'(NLB));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held 3 cycles, with a start pulse that must be ignored.
    rstN = 1'b0;
    tick(); start = 1'b1; tick(); tick();
    check_reset_outputs("reset");
    rstN = 1'b1;
    tick(); tick();
    check_value("start_ignored_in_reset", 32'(busy), 32'd0);

    // Frame 1: s_valid held high, no releases -> stall after 4 rows.
    free_run = 1'b1; vmode = 0;
    start = 1'b1; tick();
    check_value("busy_after_start", 32'(busy), 32'd1);
    wait_rows(4, 400);
    repeat (12) begin
      tick();
      check_value("stall_s_ready", 32'(s_ready), 32'd0);
      check_value("stall_valid", 32'(pixel_out_valid), 32'd0);
    end
    check_value("stall_busy", 32'(busy), 32'd1);
    check_value("stall_credits", 32'(dut.u_row_credit.count_reg), 32'd0);
    start = 1'b1; tick();
    row_done = 1'b1; tick();
    check_value("release_t1_s_ready", 32'(s_ready), 32'd0);
    tick();
    check_value("release_t2_s_ready", 32'(s_ready), 32'd1);

    // Stall again, then a release coincident with the row start.
    wait_rows(5, 400);
    repeat (8) begin
      tick();
      check_value("stall2_s_ready", 32'(s_ready), 32'd0);
    end
    check_value("stall2_credits", 32'(dut.u_row_credit.count_reg), 32'd0);
    row_done = 1'b1; tick();
    row_done = 1'b1; tick();
    check_value("coincident_credits", 32'(dut.u_row_credit.count_reg), 32'd1);
    check_value("coincident_s_ready", 32'(s_ready), 32'd1);

    // Rest of frame with s_valid toggling every 4 cycles.
    free_run = 1'b0; vmode = 1; auto_rd = 1'b1;
    wait_frames(1, 2000);
    auto_rd = 1'b0;
    repeat (3) tick();
    check_value("idle_after_frame", 32'(busy), 32'd0);
    repeat (5) begin row_done = 1'b1; tick(); end
    tick();
    check_value("credit_saturate", 32'(dut.u_row_credit.count_reg), 32'(NLB));

    // Frame 2: random s_valid, periodic releases.
    vmode = 2; auto_rd = 1'b1;
    start = 1'b1; tick();
    wait_frames(2, 3000);

    // Frame 3: reset mid-frame, discarding any held word.
    repeat (2) tick();
    start = 1'b1; tick();
    wait_rows(rows_total + 3, 1500);
    repeat (5) tick();
    rstN = 1'b0;
    tick(); tick();
    check_reset_outputs("midreset");
    rstN = 1'b1;
    tick();

    // Frame 4: clean frame after the mid-frame reset.
    start = 1'b1; tick();
    wait_frames(3, 3000);
    repeat (3) tick();
    check_value("final_idle", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
